// File: rtl/keccak_block_packer_if.sv
// Word-in / block-out bundle between the message source, the packer and the hash core.
interface keccak_block_packer_if;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned BLK_W  = 576;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic [3:0]        s_bytes;
  logic              s_ready;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_in_ready;
  logic              blk_is_last;
  logic [9:0]        blk_byte_num;
  logic              buffer_full;

  modport master (
    output s_data, s_valid, s_last, s_bytes, buffer_full,
    input  s_ready, blk_data, blk_in_ready, blk_is_last, blk_byte_num
  );

  modport slave (
    input  s_data, s_valid, s_last, s_bytes, buffer_full,
    output s_ready, blk_data, blk_in_ready, blk_is_last, blk_byte_num
  );
endinterface

// File: rtl/keccak_block_packer.sv
// Packs 64-bit message words into 576-bit Keccak rate blocks and offers them to the hash core.
module keccak_block_packer (
  input  logic                  clk,
  input  logic                  reset,
  keccak_block_packer_if.slave  bus
);
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned BLK_W     = 576;
  localparam int unsigned BLK_WORDS = 9;

  typedef enum logic [1:0] {FILL, SEND, SEND_EMPTY} state_e;

  state_e             state_q, state_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [6:0]         bcnt_q, bcnt_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               pend_empty_q, pend_empty_d;
  logic               is_last_q, is_last_d;
  logic [9:0]         byte_num_q, byte_num_d;
  logic               s_ready_q, s_ready_d;
  logic               in_ready_q, in_ready_d;

  logic [3:0]         n_bytes;
  logic [6:0]         bcnt_sum;
  logic [WORD_W-1:0]  word_masked;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      block_q      <= '0;
      pend_empty_q <= 1'b0;
      is_last_q    <= 1'b0;
      byte_num_q   <= '0;
      s_ready_q    <= 1'b1;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      block_q      <= block_d;
      pend_empty_q <= pend_empty_d;
      is_last_q    <= is_last_d;
      byte_num_q   <= byte_num_d;
      s_ready_q    <= s_ready_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state, counters and block contents
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
    block_d      = block_q;
    pend_empty_d = pend_empty_q;
    is_last_d    = is_last_q;
    byte_num_d   = byte_num_q;

    // Non-last words always count as 8 bytes; oversize counts clamp to 8
    n_bytes = 4'd8;
    if (bus.s_last && (bus.s_bytes < 4'd8)) n_bytes = bus.s_bytes;
    bcnt_sum = bcnt_q + 7'(n_bytes);

    word_masked = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_bytes) word_masked[WORD_W-1-8*i -: 8] = bus.s_data[WORD_W-1-8*i -: 8];
    end

    case (state_q)
      FILL: begin
        if (bus.s_valid && s_ready_q) begin
          for (int k = 0; k < BLK_WORDS; k++) begin
            if (wcnt_q == 4'(k)) block_d[BLK_W-1-WORD_W*k -: WORD_W] = word_masked;
          end
          wcnt_d = wcnt_q + 4'd1;
          bcnt_d = bcnt_sum;
          if (bus.s_last) begin
            state_d = SEND;
            // A message ending exactly on a block boundary needs a trailing empty block
            if (bcnt_sum == 7'd72) begin
              is_last_d    = 1'b0;
              byte_num_d   = 10'd72;
              pend_empty_d = 1'b1;
            end else begin
              is_last_d    = 1'b1;
              byte_num_d   = 10'(bcnt_sum);
            end
          end else if (wcnt_q == 4'd8) begin
            state_d    = SEND;
            is_last_d  = 1'b0;
            byte_num_d = 10'd72;
          end
        end
      end
      SEND: begin
        if (!bus.buffer_full) begin
          wcnt_d       = '0;
          bcnt_d       = '0;
          block_d      = '0;
          pend_empty_d = 1'b0;
          byte_num_d   = '0;
          if (pend_empty_q) begin
            state_d   = SEND_EMPTY;
            is_last_d = 1'b1;
          end else begin
            state_d   = FILL;
            is_last_d = 1'b0;
          end
        end
      end
      SEND_EMPTY: begin
        if (!bus.buffer_full) begin
          state_d    = FILL;
          wcnt_d     = '0;
          bcnt_d     = '0;
          block_d    = '0;
          is_last_d  = 1'b0;
          byte_num_d = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    s_ready_d  = (state_d == FILL);
    in_ready_d = (state_d != FILL);
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.blk_in_ready = in_ready_q;
  assign bus.blk_is_last  = is_last_q;
  assign bus.blk_byte_num = byte_num_q;
  assign bus.blk_data     = block_q;
endmodule

// File: tb/tb_keccak_block_packer.sv
// Directed self-checking bench for keccak_block_packer.
module tb_keccak_block_packer;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  keccak_block_packer_if bus ();

  keccak_block_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rep8(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Present one word and hold it until accepted; leaves the bench 1 time unit after the accept edge
  task automatic push(input logic [63:0] d, input logic l, input logic [3:0] b);
    int guard = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = l;
    bus.s_bytes = b;
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (guard >= 50) begin
      miscompares++;
      $display("FAIL push_timeout s_ready=%b required=1", bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_bytes = 4'd0;
  endtask

  // Wait for an offered block, check it, then let exactly one transfer happen
  task automatic take_block(input string nm, input logic [575:0] ed, input logic el, input logic [9:0] en);
    int guard = 0;
    while (bus.blk_in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (guard >= 50) begin
      miscompares++;
      $display("FAIL %s_offer_timeout blk_in_ready=%b required=1", nm, bus.blk_in_ready);
    end
    vectors++;
    if (bus.blk_data !== ed) begin
      miscompares++;
      $display("FAIL %s_data got=%h required=%h", nm, bus.blk_data, ed);
    end
    vectors++;
    if (bus.blk_is_last !== el) begin
      miscompares++;
      $display("FAIL %s_is_last got=%b required=%b", nm, bus.blk_is_last, el);
    end
    vectors++;
    if (bus.blk_byte_num !== en) begin
      miscompares++;
      $display("FAIL %s_byte_num got=%0d required=%0d", nm, bus.blk_byte_num, en);
    end
    bus.buffer_full = 1'b0;
    @(posedge clk); #1;
    bus.buffer_full = 1'b1;
  endtask

  task automatic check_idle(input string nm);
    vectors++;
    if (bus.blk_in_ready !== 1'b0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle in_ready=%b s_ready=%b required in_ready=0 s_ready=1", nm, bus.blk_in_ready, bus.s_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (bus.s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready got=%b required=1", bus.s_ready); end
    vectors++;
    if (bus.blk_in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b required=0", bus.blk_in_ready); end
    vectors++;
    if (bus.blk_is_last !== 1'b0) begin miscompares++; $display("FAIL reset_is_last got=%b required=0", bus.blk_is_last); end
    vectors++;
    if (bus.blk_byte_num !== 10'd0) begin miscompares++; $display("FAIL reset_byte_num got=%0d required=0", bus.blk_byte_num); end
    vectors++;
    if (bus.blk_data !== 576'd0) begin miscompares++; $display("FAIL reset_data got=%h required=0", bus.blk_data); end
  endtask

  // Eight words, last one full: partial block of 64 bytes, free-running core
  task automatic test_partial_block();
    logic [575:0] exp = '0;
    bus.buffer_full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp[575-64*k -: 64] = rep8(8'(k + 1));
      push(rep8(8'(k + 1)), (k == 7), 4'd8);
    end
    vectors++;
    if (bus.blk_in_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_latency in_ready=%b s_ready=%b required in_ready=1 s_ready=0", bus.blk_in_ready, bus.s_ready);
    end
    vectors++;
    if (bus.blk_data !== exp || bus.blk_is_last !== 1'b1 || bus.blk_byte_num !== 10'd64) begin
      miscompares++;
      $display("FAIL partial_block last=%b num=%0d data=%h required last=1 num=64 data=%h", bus.blk_is_last, bus.blk_byte_num, bus.blk_data, exp);
    end
    @(posedge clk); #1;
    check_idle("partial_after");
    bus.buffer_full = 1'b1;
  endtask

  // Nine full words then a 3-byte tail word
  task automatic test_spill();
    logic [575:0] exp = '0;
    for (int k = 0; k < 9; k++) begin
      exp[575-64*k -: 64] = rep8(8'(8'h10 + k));
      push(rep8(8'(8'h10 + k)), 1'b0, 4'd0);
    end
    take_block("spill_first", exp, 1'b0, 10'd72);
    check_idle("spill_between");
    push(64'hAABBCCDDEEFF0011, 1'b1, 4'd3);
    exp = '0;
    exp[575:552] = 24'hAABBCC;
    take_block("spill_second", exp, 1'b1, 10'd3);
    check_idle("spill_after");
  endtask

  // Message ends exactly on a block boundary: full block then empty last block
  task automatic test_exact_full();
    logic [575:0] exp = '0;
    for (int k = 0; k < 9; k++) begin
      exp[575-64*k -: 64] = rep8(8'(8'h30 + k));
      push(rep8(8'(8'h30 + k)), (k == 8), 4'd8);
    end
    take_block("exact_first", exp, 1'b0, 10'd72);
    vectors++;
    if (bus.blk_in_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL exact_empty_offer in_ready=%b s_ready=%b required in_ready=1 s_ready=0", bus.blk_in_ready, bus.s_ready);
    end
    take_block("exact_empty", 576'd0, 1'b1, 10'd0);
    check_idle("exact_after");
  endtask

  // Empty message, plus oversize s_bytes clamped to 8
  task automatic test_empty_and_clamp();
    logic [575:0] exp = '0;
    push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    take_block("empty_msg", 576'd0, 1'b1, 10'd0);
    check_idle("empty_after");
    push(64'hDEADBEEFCAFEF00D, 1'b1, 4'd12);
    exp[575:512] = 64'hDEADBEEFCAFEF00D;
    take_block("clamp", exp, 1'b1, 10'd8);
  endtask

  // Core stalls for 5 cycles while a block is offered
  task automatic test_stall();
    logic [575:0] exp = '0;
    exp[575:512] = 64'h0123456789ABCDEF;
    exp[511:472] = 40'hFEDCBA9876;
    push(64'h0123456789ABCDEF, 1'b0, 4'd0);
    push(64'hFEDCBA9876543210, 1'b1, 4'd5);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.blk_in_ready !== 1'b1 || bus.s_ready !== 1'b0 || bus.blk_data !== exp ||
          bus.blk_is_last !== 1'b1 || bus.blk_byte_num !== 10'd13) begin
        miscompares++;
        $display("FAIL stall_hold cycle=%0d in_ready=%b s_ready=%b last=%b num=%0d required 1 0 1 13", c,
                 bus.blk_in_ready, bus.s_ready, bus.blk_is_last, bus.blk_byte_num);
      end
      @(posedge clk); #1;
    end
    take_block("stall_release", exp, 1'b1, 10'd13);
    for (int c = 0; c < 3; c++) begin
      check_idle("stall_no_dup");
      @(posedge clk); #1;
    end
  endtask

  // Reset mid-message abandons the partial block
  task automatic test_reset_mid();
    logic [575:0] exp = '0;
    for (int k = 0; k < 4; k++) push(rep8(8'(8'h50 + k)), 1'b0, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.blk_in_ready !== 1'b0 || bus.blk_is_last !== 1'b0 ||
        bus.blk_byte_num !== 10'd0 || bus.blk_data !== 576'd0) begin
      miscompares++;
      $display("FAIL reset_mid s_ready=%b in_ready=%b last=%b num=%0d required 1 0 0 0 with zero data",
               bus.s_ready, bus.blk_in_ready, bus.blk_is_last, bus.blk_byte_num);
    end
    push(64'h1234567890ABCDEF, 1'b1, 4'd2);
    exp[575:560] = 16'h1234;
    take_block("after_reset", exp, 1'b1, 10'd2);
    check_idle("after_reset_idle");
  endtask

  initial begin
    reset           = 1'b1;
    bus.s_data      = '0;
    bus.s_valid     = 1'b0;
    bus.s_last      = 1'b0;
    bus.s_bytes     = 4'd0;
    bus.buffer_full = 1'b1;
    test_reset();
    test_partial_block();
    test_spill();
    test_exact_full();
    test_empty_and_clamp();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keccak_block_packer.md
KECCAK_BLOCK_PACKER -- requirements
Module: keccak_block_packer

Interface
REQ-001 Parameters: none; the block width (576 bits = 72 bytes) and the word width (64 bits = 8 bytes) are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_data  input  64  message word; first message byte is in bits [63:56].
REQ-005 s_valid  input  1  s_data, s_last and s_bytes are valid this cycle.
REQ-006 s_last  input  1  this word is the final word of the message.
REQ-007 s_bytes  input  4  count of valid bytes in a word with s_last=1, range 0..8; ignored when s_last=0, and the word then counts as 8 bytes.
REQ-008 s_ready  output  1  packer can accept a word this cycle.
REQ-009 blk_data  output  576  packed block; word k of the block occupies bits [575-64k : 512-64k].
REQ-010 blk_in_ready  output  1  block offered to the hash core (drives the core's in_ready).
REQ-011 blk_is_last  output  1  offered block ends the message.
REQ-012 blk_byte_num  output  10  count of valid bytes in the offered block, range 0..72.
REQ-013 buffer_full  input  1  hash core cannot accept a block this cycle.

Function
REQ-014 A word transfer occurs on any rising edge with s_valid=1 and s_ready=1.
REQ-015 A block transfer occurs on any rising edge with blk_in_ready=1 and buffer_full=0.
REQ-016 States: FILL, SEND, SEND_EMPTY.
REQ-017 s_ready=1 only in FILL; s_ready is a registered/state-decoded signal with no combinational path from buffer_full.
REQ-018 In FILL, word counter wcnt (0..8) and byte counter bcnt (0..72) track the current block.
- An accepted word is written at slot wcnt.
- bcnt advances by 8 for a non-last word, or by s_bytes for a last word.
REQ-019 Bytes beyond the valid count in a last word, and all unwritten slots, SHALL be zero in blk_data.
REQ-020 FILL->SEND when a non-last word fills slot 8.
- Outputs: blk_is_last=0, blk_byte_num=72.
REQ-021 FILL->SEND when a last word is accepted and the block holds fewer than 72 valid bytes.
- Outputs: blk_is_last=1, blk_byte_num=bcnt (0..71).
REQ-022 A last word that brings the block to exactly 72 bytes SHALL cause two transfers:
- first a full block with blk_is_last=0 and blk_byte_num=72;
- then state SEND_EMPTY, offering an all-zero block with blk_is_last=1 and blk_byte_num=0.
REQ-023 An empty message (first word has s_last=1, s_bytes=0) SHALL produce one block with blk_is_last=1, blk_byte_num=0, and blk_data all zero.
REQ-024 blk_in_ready SHALL assert in the cycle after the word that completes the block is accepted, giving a latency of 1 cycle.
REQ-025 blk_in_ready SHALL be 1 throughout SEND and SEND_EMPTY.
REQ-026 blk_data, blk_is_last and blk_byte_num SHALL stay stable while blk_in_ready=1 and no block transfer has occurred.
REQ-027 When buffer_full=1, blk_in_ready SHALL stay high with blk_data, blk_is_last and blk_byte_num held, until the block transfer occurs; no block is dropped or duplicated.
REQ-028 On block transfer in SEND:
- go to SEND_EMPTY if REQ-022 applies;
- otherwise go to FILL with wcnt=0, bcnt=0 and the block register cleared.
REQ-029 On block transfer in SEND_EMPTY, go to FILL with wcnt=0, bcnt=0 and the block register cleared.
REQ-030 blk_in_ready SHALL deassert in the cycle after a block transfer unless the next state is SEND_EMPTY; one transfer per offered block.
REQ-031 A new message may begin in the cycle after the final block transfer; messages are processed back-to-back with no further gap.
REQ-032 s_bytes>8 on a last word SHALL be treated as 8.

Reset
REQ-033 A synchronous reset SHALL set:
- state=FILL;
- wcnt=0, bcnt=0, block register=0;
- s_ready=1, blk_in_ready=0, blk_is_last=0, blk_byte_num=0, blk_data=0.
REQ-034 Reset asserted mid-message or while a block is offered SHALL abandon that block; no block transfer occurs on the reset edge or afterward for the abandoned data.

Verification
REQ-035 Eight words 0x0101..01 through 0x0808..08, the 8th with s_last=1 and s_bytes=8, buffer_full=0 -> one block offered one cycle later:
- blk_byte_num=64, blk_is_last=1;
- blk_data[575:512]=0x0101..01, blk_data[63:0]=0.
REQ-036 Nine full words followed by one word with s_last=1 and s_bytes=3 (0xAABBCC..) -> two blocks:
- first: blk_byte_num=72, blk_is_last=0;
- second: blk_byte_num=3, blk_is_last=1, blk_data[575:552]=0xAABBCC, remaining bits zero.
REQ-037 Nine words with the 9th marked s_last=1 and s_bytes=8 -> two blocks:
- first: blk_byte_num=72, blk_is_last=0;
- second: all-zero block with blk_byte_num=0, blk_is_last=1.
REQ-038 Single word with s_last=1 and s_bytes=0 -> one all-zero block with blk_byte_num=0, blk_is_last=1.
REQ-039 buffer_full held at 1 for 5 cycles while a block is offered -> s_ready=0, outputs stable; exactly one block transfer when buffer_full falls.
REQ-040 Reset pulsed after 4 words are accepted -> all outputs return to reset values; a following 1-word message with s_bytes=2 yields blk_byte_num=2 and none of the earlier data.
